// File: rtl/line_fill_arbiter_pkg.sv
// Shared definitions for the line fill arbiter: FSM state encodings,
// default line geometry and a small one-hot helper.
package lfa_pkg;

    // Default line geometry shared with the caches: {tag, index} line address, 4 x 16-bit words
    localparam int LFA_ADDR_W = 14;
    localparam int LFA_LINE_W = 64;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WB   = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Convert a client index into its one-hot select vector
    function automatic logic [1:0] lfa_onehot(input logic idx);
        logic [1:0] vec;
        if (idx) begin
            vec = 2'b10;
        end else begin
            vec = 2'b01;
        end
        return vec;
    endfunction

endpackage

// File: rtl/line_fill_arbiter_if.sv
// Line-wide main memory port: the arbiter is the master, the memory the slave.
interface line_fill_arbiter_if
    import lfa_pkg::*;
#(
    parameter int ADDR_W = LFA_ADDR_W,
    parameter int LINE_W = LFA_LINE_W
);
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/line_fill_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter. A lone requester always wins; on
// contention the requester selected by rr_ptr wins. Purely combinational.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       rr_ptr,
    output logic [1:0] gnt
);

    // Resolve the one-hot grant from the request vector and priority pointer
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11: begin
                if (rr_ptr) begin
                    gnt = 2'b10;
                end else begin
                    gnt = 2'b01;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/line_fill_arbiter.sv
// Memory-side fill controller shared by the instruction cache (client 0)
// and data cache (client 1). Arbitrates round-robin, performs the optional
// dirty writeback, then the line fill, and returns the line with a one-cycle
// rdy pulse. A watchdog aborts any access that is not acknowledged in time.
// Every output is a register loaded from the next-state decode, so there is
// no combinational path from any input to any output.
module line_fill_arbiter
    import lfa_pkg::*;
#(
    parameter int ADDR_W  = LFA_ADDR_W,
    parameter int LINE_W  = LFA_LINE_W,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic              wb0,
    input  logic              wb1,
    input  logic [ADDR_W-1:0] wb_addr0,
    input  logic [ADDR_W-1:0] wb_addr1,
    input  logic [LINE_W-1:0] wb_data0,
    input  logic [LINE_W-1:0] wb_data1,
    output logic [1:0]        gnt,
    output logic [1:0]        rdy,
    output logic [LINE_W-1:0] rdata,
    output logic              err,
    output logic              err_sticky,
    line_fill_arbiter_if.master mem
);

    // Watchdog counter sized to hold TIMEOUT; one extra bit for the increment compare
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W:0] TO_LIM = (CNT_W + 1)'(TIMEOUT);

    // State and captured transaction fields
    logic [1:0]        state_r,       state_nxt_s;
    logic              win_r,         win_nxt_s;
    logic              rr_ptr_r,      rr_ptr_nxt_s;
    logic [ADDR_W-1:0] cap_addr_r,    cap_addr_nxt_s;
    logic [ADDR_W-1:0] cap_wb_addr_r, cap_wb_addr_nxt_s;
    logic [LINE_W-1:0] cap_wb_data_r, cap_wb_data_nxt_s;
    logic [CNT_W-1:0]  wdog_cnt_r,    wdog_cnt_nxt_s;

    // Registered outputs and their next values
    logic [1:0]        gnt_r,         gnt_nxt_s;
    logic [1:0]        rdy_r,         rdy_nxt_s;
    logic [LINE_W-1:0] rdata_r,       rdata_nxt_s;
    logic              err_r,         err_nxt_s;
    logic              err_sticky_r,  err_sticky_nxt_s;
    logic              mem_en_r,      mem_en_nxt_s;
    logic              mem_we_r,      mem_we_nxt_s;
    logic [ADDR_W-1:0] mem_addr_r,    mem_addr_nxt_s;
    logic [LINE_W-1:0] mem_wdata_r,   mem_wdata_nxt_s;

    logic [1:0]        arb_gnt_s;
    logic              win_sel_s;
    logic [CNT_W:0]    wdog_inc_s;
    logic              timeout_s;

    rr_arb2 u_rr_arb2 (
        .req    (req),
        .rr_ptr (rr_ptr_r),
        .gnt    (arb_gnt_s)
    );

    assign win_sel_s = arb_gnt_s[1];

    // Detect watchdog expiry: this un-acknowledged cycle would reach TIMEOUT
    always_comb begin
        wdog_inc_s = {1'b0, wdog_cnt_r} + (CNT_W + 1)'(1);
        timeout_s  = 1'b0;
        if ((TIMEOUT > 0) && ((state_r == ST_WB) || (state_r == ST_FILL)) && !mem.mem_ack) begin
            timeout_s = (wdog_inc_s == TO_LIM);
        end else begin
            timeout_s = 1'b0;
        end
    end

    // FSM next state, capture, watchdog and response data
    always_comb begin
        state_nxt_s       = state_r;
        win_nxt_s         = win_r;
        rr_ptr_nxt_s      = rr_ptr_r;
        cap_addr_nxt_s    = cap_addr_r;
        cap_wb_addr_nxt_s = cap_wb_addr_r;
        cap_wb_data_nxt_s = cap_wb_data_r;
        wdog_cnt_nxt_s    = wdog_cnt_r;
        rdata_nxt_s       = rdata_r;
        err_nxt_s         = 1'b0;
        err_sticky_nxt_s  = err_sticky_r;
        case (state_r)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    win_nxt_s      = win_sel_s;
                    wdog_cnt_nxt_s = '0;
                    if (win_sel_s) begin
                        cap_addr_nxt_s    = addr1;
                        cap_wb_addr_nxt_s = wb_addr1;
                        cap_wb_data_nxt_s = wb_data1;
                        state_nxt_s       = wb1 ? ST_WB : ST_FILL;
                    end else begin
                        cap_addr_nxt_s    = addr0;
                        cap_wb_addr_nxt_s = wb_addr0;
                        cap_wb_data_nxt_s = wb_data0;
                        state_nxt_s       = wb0 ? ST_WB : ST_FILL;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WB: begin
                if (mem.mem_ack) begin
                    state_nxt_s    = ST_FILL;
                    wdog_cnt_nxt_s = '0;
                end else if (timeout_s) begin
                    // An aborted writeback skips the fill entirely
                    state_nxt_s      = ST_RESP;
                    rdata_nxt_s      = '0;
                    err_nxt_s        = 1'b1;
                    err_sticky_nxt_s = 1'b1;
                end else begin
                    wdog_cnt_nxt_s = wdog_inc_s[CNT_W-1:0];
                end
            end
            ST_FILL: begin
                if (mem.mem_ack) begin
                    state_nxt_s = ST_RESP;
                    rdata_nxt_s = mem.mem_rdata;
                end else if (timeout_s) begin
                    state_nxt_s      = ST_RESP;
                    rdata_nxt_s      = '0;
                    err_nxt_s        = 1'b1;
                    err_sticky_nxt_s = 1'b1;
                end else begin
                    wdog_cnt_nxt_s = wdog_inc_s[CNT_W-1:0];
                end
            end
            ST_RESP: begin
                // Priority moves to the other client whether or not this grant was contested
                rr_ptr_nxt_s = ~win_r;
                state_nxt_s  = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Decode registered outputs from the next state and next captured fields
    always_comb begin
        gnt_nxt_s       = 2'b00;
        rdy_nxt_s       = 2'b00;
        mem_en_nxt_s    = 1'b0;
        mem_we_nxt_s    = 1'b0;
        mem_addr_nxt_s  = '0;
        mem_wdata_nxt_s = '0;
        case (state_nxt_s)
            ST_WB: begin
                gnt_nxt_s       = lfa_onehot(win_nxt_s);
                mem_en_nxt_s    = 1'b1;
                mem_we_nxt_s    = 1'b1;
                mem_addr_nxt_s  = cap_wb_addr_nxt_s;
                mem_wdata_nxt_s = cap_wb_data_nxt_s;
            end
            ST_FILL: begin
                gnt_nxt_s      = lfa_onehot(win_nxt_s);
                mem_en_nxt_s   = 1'b1;
                mem_addr_nxt_s = cap_addr_nxt_s;
            end
            ST_RESP: begin
                gnt_nxt_s = lfa_onehot(win_nxt_s);
                rdy_nxt_s = lfa_onehot(win_nxt_s);
            end
            default: begin
                gnt_nxt_s = 2'b00;
            end
        endcase
    end

    // State, capture and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= ST_IDLE;
            win_r         <= 1'b0;
            rr_ptr_r      <= 1'b0;
            cap_addr_r    <= '0;
            cap_wb_addr_r <= '0;
            cap_wb_data_r <= '0;
            wdog_cnt_r    <= '0;
            gnt_r         <= 2'b00;
            rdy_r         <= 2'b00;
            rdata_r       <= '0;
            err_r         <= 1'b0;
            err_sticky_r  <= 1'b0;
            mem_en_r      <= 1'b0;
            mem_we_r      <= 1'b0;
            mem_addr_r    <= '0;
            mem_wdata_r   <= '0;
        end else begin
            state_r       <= state_nxt_s;
            win_r         <= win_nxt_s;
            rr_ptr_r      <= rr_ptr_nxt_s;
            cap_addr_r    <= cap_addr_nxt_s;
            cap_wb_addr_r <= cap_wb_addr_nxt_s;
            cap_wb_data_r <= cap_wb_data_nxt_s;
            wdog_cnt_r    <= wdog_cnt_nxt_s;
            gnt_r         <= gnt_nxt_s;
            rdy_r         <= rdy_nxt_s;
            rdata_r       <= rdata_nxt_s;
            err_r         <= err_nxt_s;
            err_sticky_r  <= err_sticky_nxt_s;
            mem_en_r      <= mem_en_nxt_s;
            mem_we_r      <= mem_we_nxt_s;
            mem_addr_r    <= mem_addr_nxt_s;
            mem_wdata_r   <= mem_wdata_nxt_s;
        end
    end

    assign gnt           = gnt_r;
    assign rdy           = rdy_r;
    assign rdata         = rdata_r;
    assign err           = err_r;
    assign err_sticky    = err_sticky_r;
    assign mem.mem_en    = mem_en_r;
    assign mem.mem_we    = mem_we_r;
    assign mem.mem_addr  = mem_addr_r;
    assign mem.mem_wdata = mem_wdata_r;

endmodule
